// File: rtl/rgb_led_arbiter_if.sv
// Client-side bundle of the RGB LED arbiter: request/colour/release in, grant/busy/LED out.
interface rgb_led_arbiter_if;
  logic [3:0]  REQ;
  logic [11:0] REQ_COLOR;
  logic [3:0]  REL;
  logic [3:0]  GNT;
  logic        BUSY;
  logic [2:0]  RGB_LED;

  modport master (output REQ, REQ_COLOR, REL, input GNT, BUSY, RGB_LED);
  modport slave  (input REQ, REQ_COLOR, REL, output GNT, BUSY, RGB_LED);
endinterface

// File: rtl/rgb_led_arbiter.sv
// Round-robin time-sharing of the RGB LED among four clients, with bounded slots and dark gaps.
// Grant/release take effect on the sampling edge; idle chase runs when nobody requests.
module rgb_led_arbiter #(
  parameter int SLOT_TICKS = 24_000_000,
  parameter int GAP_TICKS  = 2_400,
  parameter int IDLE_TICKS = 24_000_000
) (
  input  logic               CLK_IN,
  input  logic               RST_N,
  rgb_led_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  localparam logic [24:0] SLOT_LAST = 25'(SLOT_TICKS - 1);
  localparam logic [24:0] GAP_LAST  = 25'(GAP_TICKS - 1);
  localparam logic [24:0] IDLE_LAST = 25'(IDLE_TICKS - 1);

  state_t      state_q, state_d;
  logic [24:0] chase_q, chase_d;
  logic [24:0] slot_q, slot_d;
  logic [24:0] gap_q, gap_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [2:0]  led_q, led_d;
  logic        busy_q, busy_d;

  logic [1:0]  win;
  logic        any_req;
  logic [2:0]  win_color;
  logic [2:0]  own_color;
  logic [3:0]  own_oh;
  logic        others_req;
  logic        own_end;

  // Scan downward so the closest requester after the pointer is assigned last and wins.
  always_comb begin
    win = ptr_q + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      if (bus.REQ[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end

  assign any_req    = |bus.REQ;
  assign win_color  = bus.REQ_COLOR[int'(win) * 3 +: 3];
  assign own_color  = bus.REQ_COLOR[int'(ptr_q) * 3 +: 3];
  assign own_oh     = 4'b0001 << ptr_q;
  assign others_req = |(bus.REQ & ~own_oh);
  assign own_end    = bus.REL[ptr_q] || !bus.REQ[ptr_q] ||
                      ((slot_q == SLOT_LAST) && others_req);

  always_comb begin
    state_d = state_q;
    chase_d = chase_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_OWN;
          ptr_d   = win;
          gnt_d   = 4'b0001 << win;
          slot_d  = '0;
          led_d   = win_color;
        end else if (chase_q == IDLE_LAST) begin
          chase_d = '0;
          led_d   = {led_q[1:0], led_q[2]};
        end else begin
          chase_d = chase_q + 25'd1;
        end
      end
      S_OWN: begin
        if (own_end) begin
          state_d = S_GAP;
          gnt_d   = '0;
          led_d   = '0;
          gap_d   = '0;
        end else begin
          led_d = own_color;
          if (slot_q != SLOT_LAST) slot_d = slot_q + 25'd1;
        end
      end
      S_GAP: begin
        if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 25'd1;
        end else if (any_req) begin
          state_d = S_OWN;
          ptr_d   = win;
          gnt_d   = 4'b0001 << win;
          slot_d  = '0;
          led_d   = win_color;
        end else begin
          state_d = S_IDLE;
          chase_d = '0;
          led_d   = 3'b001;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        led_d   = 3'b001;
        chase_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      chase_q <= '0;
      slot_q  <= '0;
      gap_q   <= '0;
      ptr_q   <= 2'd3;
      gnt_q   <= '0;
      led_q   <= 3'b001;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chase_q <= chase_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.BUSY    = busy_q;
  assign bus.RGB_LED = led_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with SLOT=8, GAP=2, IDLE=4.
module tb_rgb_led_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  rgb_led_arbiter_if bus();

  rgb_led_arbiter #(.SLOT_TICKS(8), .GAP_TICKS(2), .IDLE_TICKS(4)) dut (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [2:0] led,
                           input logic busy);
    check({tag, ".gnt"}, 12'(bus.GNT), 12'(g));
    check({tag, ".led"}, 12'(bus.RGB_LED), 12'(led));
    check({tag, ".busy"}, 12'(bus.BUSY), 12'(busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] colors [4];
    logic [2:0] exp_led;

    rst_n         = 1'b0;
    bus.REQ       = '0;
    bus.REQ_COLOR = '0;
    bus.REL       = '0;

    // Reset and idle chase
    step(2);
    check_all("reset", 4'b0000, 3'b001, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      exp_led = (i < 4) ? 3'b001 : (i < 8) ? 3'b010 : (i < 12) ? 3'b100 : 3'b001;
      check_all("idle_chase", 4'b0000, exp_led, 1'b0);
    end

    // Single owner, client 1 colour 110, later changed to 011
    bus.REQ       = 4'b0010;
    bus.REQ_COLOR = 12'h030;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_all("single_own", 4'b0010, (i < 11) ? 3'b110 : 3'b011, 1'b1);
      if (i == 10) bus.REQ_COLOR = 12'h018;
    end
    bus.REQ = 4'b0000;
    step(1);
    check_all("single_gap0", 4'b0000, 3'b000, 1'b1);
    step(1);
    check_all("single_gap1", 4'b0000, 3'b000, 1'b1);
    step(1);
    check_all("single_idle", 4'b0000, 3'b001, 1'b0);

    // Round robin with all four requesting from reset
    colors[0] = 3'b100; colors[1] = 3'b110; colors[2] = 3'b011; colors[3] = 3'b101;
    bus.REQ_COLOR = {colors[3], colors[2], colors[1], colors[0]};
    bus.REQ = 4'b1111;
    rst_n   = 1'b0;
    step(1);
    check_all("rr_reset", 4'b0000, 3'b001, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) begin
        step(1);
        check_all("rr_own", 4'b0001 << (k % 4), colors[k % 4], 1'b1);
      end
      if (k < 4) begin
        for (int j = 0; j < 2; j++) begin
          step(1);
          check_all("rr_gap", 4'b0000, 3'b000, 1'b1);
        end
      end
    end

    // Release: client 2 owns, foreign REL ignored, own REL at slot 3 ends ownership
    bus.REQ = 4'b0000;
    rst_n   = 1'b0;
    step(1);
    rst_n   = 1'b1;
    bus.REQ = 4'b0100;
    step(1);
    check_all("rel_grant", 4'b0100, colors[2], 1'b1);
    bus.REL = 4'b0001;
    step(1);
    check_all("rel_foreign", 4'b0100, colors[2], 1'b1);
    bus.REL = 4'b0000;
    step(2);
    bus.REL = 4'b0100;
    step(1);
    check_all("rel_own", 4'b0000, 3'b000, 1'b1);
    bus.REL = 4'b0000;
    step(1);
    check_all("rel_gap1", 4'b0000, 3'b000, 1'b1);
    step(1);
    check_all("rel_regrant", 4'b0100, colors[2], 1'b1);
    bus.REQ = 4'b0000;
    step(3);
    check_all("rel_idle", 4'b0000, 3'b001, 1'b0);

    // REL coincident with slot expiry while client 3 waits: one gap only
    bus.REQ = 4'b0001;
    step(1);
    check_all("sim_grant", 4'b0001, colors[0], 1'b1);
    step(7);
    check_all("sim_slot7", 4'b0001, colors[0], 1'b1);
    bus.REL = 4'b0001;
    bus.REQ = 4'b1001;
    step(1);
    check_all("sim_end", 4'b0000, 3'b000, 1'b1);
    bus.REL = 4'b0000;
    bus.REQ = 4'b1000;
    step(1);
    check_all("sim_gap1", 4'b0000, 3'b000, 1'b1);
    step(1);
    check_all("sim_next", 4'b1000, colors[3], 1'b1);

    // Reset while client 3 owns with everyone requesting
    bus.REQ = 4'b1111;
    step(1);
    check_all("mid_own", 4'b1000, colors[3], 1'b1);
    rst_n = 1'b0;
    step(1);
    check_all("mid_reset", 4'b0000, 3'b001, 1'b0);
    rst_n = 1'b1;
    step(1);
    check_all("mid_first", 4'b0001, colors[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
